pkt_ring_buffer_mq: RTL and testbench
=====================================

// Module: pkt_ring_buffer_mq
// PURPOSE
//  Next-generation packet staging ring between packet writer and PCIe DMA. Stores flits in a
//  DEPTH-entry BRAM and coalesces consecutive same-queue packets into DMA descriptors (capped
//  size, never across wrap). Issues one DMA at a time; buffer space is released only on dma_done.
// PARAMETERS
//  DWIDTH          512        flit payload width
//  DEPTH           512        flit slots in buffer (power of 2)
//  AWIDTH          $clog2(DEPTH)  flit address width
//  THRESHOLD       64         max packet flits; wrap margin; MAX_SLOT = DEPTH-THRESHOLD
//  QID_WIDTH       5          queue id width
//  MAX_MERGE_FLITS 256        max flits per coalesced descriptor (<= DEPTH-THRESHOLD)
//  DESC_DEPTH      DEPTH/2    closed-descriptor FIFO entries (power of 2)
// PORTS
//  clk                 in   1        clock
//  rst                 in   1        synchronous reset, active-high
//  wr_data             in   DWIDTH   flit payload
//  wr_sop / wr_eop     in   1        flit is first / last of packet
//  wr_addr             in   AWIDTH   flit slot
//  wr_en               in   1        write flit
//  wr_queue_id         in   QID_W    packet queue, valid with wr_en&wr_sop
//  wr_pkt_flits        in   AWIDTH   packet length in flits (1..THRESHOLD), valid with sop
//  update_valid        in   1        writer reserves update_size slots at tail
//  update_size         in   AWIDTH   flits reserved
//  wr_base_addr        out  AWIDTH   current tail
//  wr_base_addr_valid  out  1        update_valid delayed 1 cycle
//  almost_full         out  1        writer must stop reserving
//  rd_addr / rd_en     in   AWIDTH/1 DMA fetch
//  rd_valid            out  1        rd_en delayed 2 cycles
//  rd_data / rd_eop    out  DWIDTH/1 flit read, aligned with rd_valid
//  dma_start           out  1        1-cycle pulse: descriptor outputs valid
//  dma_base_addr       out  AWIDTH   first slot of descriptor
//  dma_size            out  AWIDTH   flits in descriptor
//  dma_queue           out  QID_W    queue of descriptor
//  dma_done            in   1        current DMA complete; releases dma_size slots
// BEHAVIOUR
//  Reset: tail, head, last_tail, desc ptrs, open_valid cleared; all outputs 0; state IDLE.
//  Reset mid-DMA abandons transfer; later dma_done ignored (state IDLE).
//  Tail: on update_valid, if tail+update_size < MAX_SLOT tail+=size; else tail<=0,
//   last_tail<=tail+update_size. wrap = (tail<head).
//  occupied = wrap ? last_tail-head+tail : tail-head; free = DEPTH-occupied-1.
//  almost_full (registered) = free < 2*THRESHOLD OR closed FIFO holds >= DESC_DEPTH-2.
//  Descriptor {base,size,queue}: one open (register), closed ones in FIFO.
//  On wr_en&wr_sop: merge into open iff open_valid, same queue, wr_addr > open.base,
//   open.size+wr_pkt_flits <= MAX_MERGE_FLITS; else push open (if valid) to FIFO,
//   open <= {wr_addr, wr_pkt_flits, wr_queue_id}.
//  FSM IDLE: if FIFO non-empty, pop head -> dma_* outputs, dma_start=1, ->WAIT.
//   Else if open_valid and no wr_en&wr_sop this cycle: launch from open, open_valid<=0, ->WAIT.
//   (sop in same cycle defers launch one cycle; merge/push applied first.)
//  FSM WAIT: dma_done -> IDLE; head <= (wrap && head+dma_size==last_tail) ? 0 : head+dma_size.
//   dma_done in IDLE ignored. dma_done no earlier than 3 cycles after dma_start.
//  Launch on same cycle as push: FIFO pop/push concurrent; count updates by net change.
//  Fetch: BRAM read latency 2; rd_valid/rd_data/rd_eop registered. Same-cycle rd/wr same addr: old data.
//  All pointer arithmetic modulo 2^AWIDTH; DESC ptrs modulo DESC_DEPTH.
// CONFIGURATION
//  RB_COALESCE_EN defined: merging as above. Undefined: every sop closes open descriptor
//   (one descriptor per packet); MAX_MERGE_FLITS unused; all other behaviour identical.
// TESTING
//  Single 4-flit pkt q3 at 0 -> dma_start base 0 size 4 queue 3; dma_done -> head=4.
//  Hold in WAIT; 3 pkts q1 (2,3,4 flits) -> one DMA size 9 (COALESCE_EN) / three DMAs (not).
//  In WAIT: q1,q2,q1 pkts -> three descriptors issued in order, queues 1,2,1.
//  tail=440, update 16 -> tail 0, last_tail 456; pkt at 0 q same -> not merged; head wraps 456->0.
//  Reserve until free<128 -> almost_full=1 next cycle; release via dma_done -> deasserts.
//  rst during WAIT then dma_done -> no head change, dma_start stays 0, all outputs 0.

Source files
------------

// File: rtl/pkt_ring_buffer_mq_if.sv
// Writer, fetch and DMA descriptor bundle of pkt_ring_buffer_mq.
// master = packet writer / DMA engine side, slave = the ring buffer.
interface pkt_ring_buffer_mq_if #(
    parameter int DWIDTH    = 512,
    parameter int AWIDTH    = 9,
    parameter int QID_WIDTH = 5
);
    logic [DWIDTH-1:0]    wr_data;
    logic                 wr_sop;
    logic                 wr_eop;
    logic [AWIDTH-1:0]    wr_addr;
    logic                 wr_en;
    logic [QID_WIDTH-1:0] wr_queue_id;
    logic [AWIDTH-1:0]    wr_pkt_flits;
    logic                 update_valid;
    logic [AWIDTH-1:0]    update_size;
    logic [AWIDTH-1:0]    wr_base_addr;
    logic                 wr_base_addr_valid;
    logic                 almost_full;
    logic [AWIDTH-1:0]    rd_addr;
    logic                 rd_en;
    logic                 rd_valid;
    logic [DWIDTH-1:0]    rd_data;
    logic                 rd_eop;
    logic                 dma_start;
    logic [AWIDTH-1:0]    dma_base_addr;
    logic [AWIDTH-1:0]    dma_size;
    logic [QID_WIDTH-1:0] dma_queue;
    logic                 dma_done;

    modport master (
        output wr_data, wr_sop, wr_eop, wr_addr, wr_en, wr_queue_id, wr_pkt_flits,
        output update_valid, update_size, rd_addr, rd_en, dma_done,
        input  wr_base_addr, wr_base_addr_valid, almost_full, rd_valid, rd_data, rd_eop,
        input  dma_start, dma_base_addr, dma_size, dma_queue
    );

    modport slave (
        input  wr_data, wr_sop, wr_eop, wr_addr, wr_en, wr_queue_id, wr_pkt_flits,
        input  update_valid, update_size, rd_addr, rd_en, dma_done,
        output wr_base_addr, wr_base_addr_valid, almost_full, rd_valid, rd_data, rd_eop,
        output dma_start, dma_base_addr, dma_size, dma_queue
    );
endinterface

// File: rtl/pkt_ring_buffer_mq.sv
// Packet staging ring between packet writer and PCIe DMA, one DMA in flight at a time.
// Define RB_COALESCE_EN to merge consecutive same-queue packets into one descriptor.
module pkt_ring_buffer_mq #(
    parameter int DWIDTH          = 512,
    parameter int DEPTH           = 512,
    parameter int AWIDTH          = $clog2(DEPTH),
    parameter int THRESHOLD       = 64,
    parameter int QID_WIDTH       = 5,
    parameter int MAX_MERGE_FLITS = 256,
    parameter int DESC_DEPTH      = DEPTH / 2
) (
    input logic                 clk,
    input logic                 rst,
    pkt_ring_buffer_mq_if.slave bus
);
    localparam int MAX_SLOT = DEPTH - THRESHOLD;
    localparam int DAW      = $clog2(DESC_DEPTH);

`ifdef RB_COALESCE_EN
    localparam bit COALESCE_EN = 1'b1;
`else
    localparam bit COALESCE_EN = 1'b0;
`endif

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    typedef struct packed {
        logic [AWIDTH-1:0]    base;
        logic [AWIDTH-1:0]    size;
        logic [QID_WIDTH-1:0] queue;
    } desc_t;

    state_t            state;
    logic [AWIDTH-1:0] tail;
    logic [AWIDTH-1:0] head;
    logic [AWIDTH-1:0] last_tail;
    logic [AWIDTH-1:0] tail_sum;
    logic [AWIDTH-1:0] head_sum;
    logic [AWIDTH-1:0] occupied;
    logic [AWIDTH:0]   free_slots;
    logic              wrap;

    desc_t             fifo_mem [DESC_DEPTH];
    logic [DAW-1:0]    fifo_wr_ptr;
    logic [DAW-1:0]    fifo_rd_ptr;
    logic [DAW:0]      fifo_count;
    desc_t             open_desc;
    logic              open_valid;
    logic              sop_fire;
    logic              merge_ok;
    logic              push;
    logic              pop;
    logic              launch_open;
    logic [AWIDTH:0]   merge_sum;

    logic [DWIDTH:0]   mem [DEPTH];
    logic [DWIDTH:0]   rd_stage;
    logic              rd_stage_valid;

    assign tail_sum   = tail + bus.update_size;
    assign head_sum   = head + bus.dma_size;
    assign wrap       = tail < head;
    assign occupied   = wrap ? (last_tail - head + tail) : (tail - head);
    assign free_slots = (AWIDTH+1)'(DEPTH - 1) - {1'b0, occupied};

    // A sop in the same cycle as an open-descriptor launch wins; the launch waits a cycle.
    assign sop_fire    = bus.wr_en && bus.wr_sop;
    assign merge_sum   = {1'b0, open_desc.size} + {1'b0, bus.wr_pkt_flits};
    assign merge_ok    = COALESCE_EN && open_valid && (bus.wr_queue_id == open_desc.queue) &&
                         (bus.wr_addr > open_desc.base) &&
                         (merge_sum <= (AWIDTH+1)'(MAX_MERGE_FLITS));
    assign push        = sop_fire && open_valid && !merge_ok;
    assign pop         = (state == ST_IDLE) && (fifo_count != '0);
    assign launch_open = (state == ST_IDLE) && (fifo_count == '0) && open_valid && !sop_fire;

    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            mem[bus.wr_addr] <= {bus.wr_eop, bus.wr_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_stage       <= '0;
            rd_stage_valid <= 1'b0;
            bus.rd_valid   <= 1'b0;
            bus.rd_data    <= '0;
            bus.rd_eop     <= 1'b0;
        end else begin
            rd_stage_valid <= bus.rd_en;
            if (bus.rd_en) begin
                rd_stage <= mem[bus.rd_addr];
            end
            bus.rd_valid <= rd_stage_valid;
            bus.rd_data  <= rd_stage[DWIDTH-1:0];
            bus.rd_eop   <= rd_stage[DWIDTH];
        end
    end

    // wr_base_addr returns the base of the reservation just made, even when it wraps the tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            tail                   <= '0;
            last_tail              <= '0;
            bus.wr_base_addr       <= '0;
            bus.wr_base_addr_valid <= 1'b0;
        end else begin
            bus.wr_base_addr_valid <= bus.update_valid;
            if (bus.update_valid) begin
                bus.wr_base_addr <= tail;
                if ({1'b0, tail_sum} < (AWIDTH+1)'(MAX_SLOT)) begin
                    tail <= tail_sum;
                end else begin
                    tail      <= '0;
                    last_tail <= tail_sum;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.almost_full <= 1'b0;
        end else begin
            bus.almost_full <= (free_slots < (AWIDTH+1)'(2 * THRESHOLD)) ||
                               (fifo_count >= (DAW+1)'(DESC_DEPTH - 2));
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[fifo_wr_ptr] <= open_desc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_wr_ptr <= '0;
            fifo_rd_ptr <= '0;
            fifo_count  <= '0;
            open_desc   <= '0;
            open_valid  <= 1'b0;
        end else begin
            if (push) begin
                fifo_wr_ptr <= fifo_wr_ptr + DAW'(1);
            end
            if (pop) begin
                fifo_rd_ptr <= fifo_rd_ptr + DAW'(1);
            end
            fifo_count <= fifo_count + (DAW+1)'(push) - (DAW+1)'(pop);
            if (sop_fire) begin
                open_valid <= 1'b1;
                if (merge_ok) begin
                    open_desc.size <= merge_sum[AWIDTH-1:0];
                end else begin
                    open_desc <= {bus.wr_addr, bus.wr_pkt_flits, bus.wr_queue_id};
                end
            end else if (launch_open) begin
                open_valid <= 1'b0;
            end
        end
    end

    // Space is handed back only on dma_done; a descriptor ending at last_tail wraps head to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= ST_IDLE;
            head              <= '0;
            bus.dma_start     <= 1'b0;
            bus.dma_base_addr <= '0;
            bus.dma_size      <= '0;
            bus.dma_queue     <= '0;
        end else begin
            bus.dma_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        {bus.dma_base_addr, bus.dma_size, bus.dma_queue} <= fifo_mem[fifo_rd_ptr];
                        bus.dma_start <= 1'b1;
                        state         <= ST_WAIT;
                    end else if (launch_open) begin
                        {bus.dma_base_addr, bus.dma_size, bus.dma_queue} <= open_desc;
                        bus.dma_start <= 1'b1;
                        state         <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.dma_done) begin
                        head  <= (wrap && (head_sum == last_tail)) ? '0 : head_sum;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pkt_ring_buffer_mq.sv
// Directed bench for pkt_ring_buffer_mq; descriptor expectations follow RB_COALESCE_EN.
module tb_pkt_ring_buffer_mq;
    localparam int DW = 512;
    localparam int AW = 9;
    localparam int QW = 5;

    typedef struct packed {
        logic [AW-1:0] base;
        logic [AW-1:0] size;
        logic [QW-1:0] queue;
    } desc_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    checks = 0;
    int    failures = 0;
    desc_t seen[$];

    always #5 clk = ~clk;

    pkt_ring_buffer_mq_if #(.DWIDTH(DW), .AWIDTH(AW), .QID_WIDTH(QW)) bus ();

    pkt_ring_buffer_mq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(negedge clk) begin
        if (bus.dma_start) begin
            seen.push_back({bus.dma_base_addr, bus.dma_size, bus.dma_queue});
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [DW-1:0] pat(input int seed);
        logic [DW-1:0] r;
        for (int k = 0; k < DW / 32; k++) begin
            r[k*32 +: 32] = 32'hC0DE_0000 ^ (seed * 32'h0001_9E37) ^ 32'(k);
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setIdle();
        bus.wr_data      = '0;
        bus.wr_sop       = 1'b0;
        bus.wr_eop       = 1'b0;
        bus.wr_addr      = '0;
        bus.wr_en        = 1'b0;
        bus.wr_queue_id  = '0;
        bus.wr_pkt_flits = '0;
        bus.update_valid = 1'b0;
        bus.update_size  = '0;
        bus.rd_addr      = '0;
        bus.rd_en        = 1'b0;
        bus.dma_done     = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Writes a whole packet; the reservation (if any) rides on the sop flit.
    task automatic applyStimulus(input int addr, input int nflits, input int q, input int reserve);
        for (int i = 0; i < nflits; i++) begin
            bus.wr_en        = 1'b1;
            bus.wr_sop       = (i == 0);
            bus.wr_eop       = (i == nflits - 1);
            bus.wr_addr      = AW'(addr + i);
            bus.wr_data      = pat(addr + i);
            bus.wr_queue_id  = QW'(q);
            bus.wr_pkt_flits = AW'(nflits);
            bus.update_valid = (i == 0) && (reserve != 0);
            bus.update_size  = AW'(reserve);
            step();
            if (i == 0 && reserve != 0) begin
                checkOutput("wr_base_valid", DW'(bus.wr_base_addr_valid), DW'(1));
                checkOutput("wr_base_addr", DW'(bus.wr_base_addr), DW'(addr));
            end
        end
        setIdle();
    endtask

    task automatic popDesc(input string tag, input int base, input int size, input int q);
        desc_t d;
        int n = 0;
        while (seen.size() == 0 && n < 60) begin
            step();
            n++;
        end
        checkOutput({tag, "_issued"}, DW'(seen.size() != 0), DW'(1));
        if (seen.size() != 0) begin
            d = seen.pop_front();
            checkOutput({tag, "_base"}, DW'(d.base), DW'(base));
            checkOutput({tag, "_size"}, DW'(d.size), DW'(size));
            checkOutput({tag, "_queue"}, DW'(d.queue), DW'(q));
        end
    endtask

    task automatic completeDma();
        repeat (3) step();
        bus.dma_done = 1'b1;
        step();
        bus.dma_done = 1'b0;
    endtask

    task automatic readCheck(input string tag, input int addr, input logic [DW-1:0] data, input logic eop);
        bus.rd_en   = 1'b1;
        bus.rd_addr = AW'(addr);
        step();
        bus.rd_en = 1'b0;
        checkOutput({tag, "_lat1"}, DW'(bus.rd_valid), DW'(0));
        step();
        checkOutput({tag, "_valid"}, DW'(bus.rd_valid), DW'(1));
        checkOutput({tag, "_data"}, bus.rd_data, data);
        checkOutput({tag, "_eop"}, DW'(bus.rd_eop), DW'(eop));
    endtask

    initial begin
        int addr;
        setIdle();
        rst = 1'b1;
        repeat (3) step();
        checkOutput("rst_dma_start", DW'(bus.dma_start), DW'(0));
        checkOutput("rst_dma_base", DW'(bus.dma_base_addr), DW'(0));
        checkOutput("rst_dma_size", DW'(bus.dma_size), DW'(0));
        checkOutput("rst_almost_full", DW'(bus.almost_full), DW'(0));
        checkOutput("rst_wb_valid", DW'(bus.wr_base_addr_valid), DW'(0));
        checkOutput("rst_rd_valid", DW'(bus.rd_valid), DW'(0));
        rst = 1'b0;
        step();
        checkOutput("rst_head", DW'(dut.head), DW'(0));
        checkOutput("rst_tail", DW'(dut.tail), DW'(0));

        $display("[TB] single 4-flit packet on queue 3");
        applyStimulus(0, 4, 3, 4);
        popDesc("t1", 0, 4, 3);
        completeDma();
        checkOutput("t1_head", DW'(dut.head), DW'(4));
        readCheck("rd0", 0, pat(0), 1'b0);
        readCheck("rd3", 3, pat(3), 1'b1);

        $display("[TB] same-cycle read/write returns old data");
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(500);
        bus.wr_data = pat(1000);
        step();
        bus.wr_data = pat(2000);
        bus.rd_en   = 1'b1;
        bus.rd_addr = AW'(500);
        step();
        setIdle();
        step();
        checkOutput("rw_old_data", bus.rd_data, pat(1000));
        readCheck("rw_new", 500, pat(2000), 1'b0);

        $display("[TB] three queue-1 packets while a DMA is in flight");
        applyStimulus(4, 1, 7, 1);
        popDesc("t2_hold", 4, 1, 7);
        applyStimulus(5, 2, 1, 2);
        applyStimulus(7, 3, 1, 3);
        applyStimulus(10, 4, 1, 4);
        completeDma();
        checkOutput("t2_head_hold", DW'(dut.head), DW'(5));
`ifdef RB_COALESCE_EN
        popDesc("t2_merged", 5, 9, 1);
        completeDma();
`else
        popDesc("t2_a", 5, 2, 1);
        completeDma();
        popDesc("t2_b", 7, 3, 1);
        completeDma();
        popDesc("t2_c", 10, 4, 1);
        completeDma();
`endif
        checkOutput("t2_head", DW'(dut.head), DW'(14));

        $display("[TB] interleaved queues 1,2,1 keep their order");
        applyStimulus(14, 1, 4, 1);
        popDesc("t3_hold", 14, 1, 4);
        applyStimulus(15, 2, 1, 2);
        applyStimulus(17, 2, 2, 2);
        applyStimulus(19, 2, 1, 2);
        completeDma();
        popDesc("t3_q1a", 15, 2, 1);
        completeDma();
        popDesc("t3_q2", 17, 2, 2);
        completeDma();
        popDesc("t3_q1b", 19, 2, 1);
        completeDma();
        checkOutput("t3_head", DW'(dut.head), DW'(21));

        $display("[TB] fill to tail 440, then wrap");
        addr = 21;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(addr, 64, 5, 64);
            popDesc("t4_fill", addr, 64, 5);
            completeDma();
            addr += 64;
        end
        applyStimulus(405, 35, 5, 35);
        popDesc("t4_last", 405, 35, 5);
        checkOutput("t4_tail440", DW'(dut.tail), DW'(440));
        applyStimulus(440, 16, 6, 16);
        checkOutput("t4_tail_wrap", DW'(dut.tail), DW'(0));
        checkOutput("t4_last_tail", DW'(dut.last_tail), DW'(456));
        applyStimulus(0, 4, 6, 4);
        completeDma();
        checkOutput("t4_head440", DW'(dut.head), DW'(440));
        popDesc("t4_pre_wrap", 440, 16, 6);
        completeDma();
        checkOutput("t4_head_wrap", DW'(dut.head), DW'(0));
        popDesc("t4_post_wrap", 0, 4, 6);
        completeDma();
        checkOutput("t4_head4", DW'(dut.head), DW'(4));

        $display("[TB] almost_full around free=128");
        bus.update_valid = 1'b1;
        bus.update_size  = AW'(383);
        step();
        bus.update_valid = 1'b0;
        step();
        checkOutput("af_free128", DW'(bus.almost_full), DW'(0));
        bus.update_valid = 1'b1;
        bus.update_size  = AW'(1);
        step();
        bus.update_valid = 1'b0;
        checkOutput("af_registered", DW'(bus.almost_full), DW'(0));
        step();
        checkOutput("af_free127", DW'(bus.almost_full), DW'(1));
        applyStimulus(4, 64, 8, 0);
        popDesc("af_release", 4, 64, 8);
        completeDma();
        step();
        step();
        checkOutput("af_deassert", DW'(bus.almost_full), DW'(0));

        $display("[TB] reset while a DMA is outstanding");
        applyStimulus(388, 2, 9, 2);
        popDesc("rst_pend", 388, 2, 9);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        completeDma();
        repeat (3) step();
        checkOutput("rw_head", DW'(dut.head), DW'(0));
        checkOutput("rw_tail", DW'(dut.tail), DW'(0));
        checkOutput("rw_no_start", DW'(seen.size()), DW'(0));
        checkOutput("rw_dma_start", DW'(bus.dma_start), DW'(0));
        checkOutput("rw_dma_base", DW'(bus.dma_base_addr), DW'(0));
        checkOutput("rw_dma_size", DW'(bus.dma_size), DW'(0));
        checkOutput("rw_dma_queue", DW'(bus.dma_queue), DW'(0));
        checkOutput("rw_almost_full", DW'(bus.almost_full), DW'(0));
        checkOutput("rw_wb_addr", DW'(bus.wr_base_addr), DW'(0));
        checkOutput("rw_wb_valid", DW'(bus.wr_base_addr_valid), DW'(0));
        checkOutput("rw_rd_valid", DW'(bus.rd_valid), DW'(0));
        checkOutput("rw_rd_data", bus.rd_data, DW'(0));
        checkOutput("rw_rd_eop", DW'(bus.rd_eop), DW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
